// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared encodings for the multicycle MIPS control unit.
// Holds the state codes, the opcode/funct values it recognises, the ULA
// operation codes, every datapath select encoding and the exception codes.
package cpu_ctrl_pkg;

    // State register encoding, also exported on the debug 'state' port.
    typedef logic [4:0] state_t;

    localparam state_t S_RESET      = 5'd0;
    localparam state_t S_FETCH      = 5'd1;
    localparam state_t S_FETCH_WAIT = 5'd2;
    localparam state_t S_DECODE     = 5'd3;
    localparam state_t S_EXEC       = 5'd4;
    localparam state_t S_WB         = 5'd5;
    localparam state_t S_SLT        = 5'd6;
    localparam state_t S_ADDR       = 5'd7;
    localparam state_t S_MEM_RD     = 5'd8;
    localparam state_t S_MEM_WAIT   = 5'd9;
    localparam state_t S_MEM_WB     = 5'd10;
    localparam state_t S_MEM_WR     = 5'd11;
    localparam state_t S_BRANCH     = 5'd12;
    localparam state_t S_JR         = 5'd13;
    localparam state_t S_LUI        = 5'd14;
    localparam state_t S_JUMP       = 5'd15;
    localparam state_t S_JAL1       = 5'd16;
    localparam state_t S_JAL2       = 5'd17;
    localparam state_t S_EXC        = 5'd18;
    localparam state_t S_EXC_WAIT   = 5'd19;
    localparam state_t S_EXC_JUMP   = 5'd20;

    // Primary opcodes (instr[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0]).
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ula32 operation select.
    typedef enum logic [2:0] {
        ULA_PASS = 3'b000,
        ULA_ADD  = 3'b001,
        ULA_SUB  = 3'b010,
        ULA_AND  = 3'b011,
        ULA_CMP  = 3'b111
    } ula_t;

    // Memory address source.
    typedef enum logic [1:0] {
        IORD_PC     = 2'd0,
        IORD_ALURES = 2'd1,
        IORD_ALUOUT = 2'd2,
        IORD_EXCVEC = 2'd3
    } iord_t;

    // Register-file write address source.
    typedef enum logic [1:0] {
        RD_RT = 2'd0,
        RD_RD = 2'd1,
        RD_RA = 2'd2,
        RD_SP = 2'd3
    } regdist_t;

    // Register-file write data source.
    typedef enum logic [2:0] {
        MTR_ALUOUT = 3'd0,
        MTR_LS     = 3'd1,
        MTR_LUI    = 3'd4,
        MTR_SLT    = 3'd5,
        MTR_SP     = 3'd6
    } memtoreg_t;

    // ALU operand A source.
    typedef enum logic [1:0] {
        SRCA_PC  = 2'd0,
        SRCA_A   = 2'd1,
        SRCA_MDR = 2'd3
    } srca_t;

    // ALU operand B source.
    typedef enum logic [2:0] {
        SRCB_B     = 3'd0,
        SRCB_FOUR  = 3'd1,
        SRCB_IMM   = 3'd2,
        SRCB_BROFF = 3'd3
    } srcb_t;

    // Next-PC source.
    typedef enum logic [1:0] {
        PC_ALURES = 2'd0,
        PC_ALUOUT = 2'd1,
        PC_JUMP   = 2'd2,
        PC_EPC    = 2'd3
    } pcsrc_t;

    // Exception cause, selects the vector slot (253 opcode, 254 overflow).
    typedef enum logic [1:0] {
        EXC_OPCODE = 2'd0,
        EXC_OVF    = 2'd1
    } exc_t;

    // Instruction classification produced by ctrl_decode.
    typedef struct packed {
        state_t dispatch;    // state entered after DECODE
        logic   illegal;     // encoding outside the supported instruction set
        ula_t   exec_ula;    // ALU operation used in EXEC
        logic   exec_traps;  // EXEC raises an exception on overflow
        logic   is_rtype;    // opcode 0: rd destination, B operand
        logic   is_load;     // lw rather than sw in ADDR
        logic   is_bne;      // bne rather than beq in BRANCH
    } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational instruction classifier. Maps opcode/funct to
// the state DECODE dispatches to, flags unimplemented encodings, and
// supplies the per-instruction details the later states need.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output dec_t       dec
);

    // Classify the instruction held in the IR.
    always_comb begin
        // NOTE: the whole struct is defaulted first; every case arm then only
        // overrides fields, so no path leaves a field unassigned and no latch
        // can be inferred.
        dec            = '0;
        dec.dispatch   = S_EXC;
        dec.illegal    = 1'b1;
        dec.exec_ula   = ULA_ADD;
        dec.is_rtype   = (opcode == OP_RTYPE);
        dec.is_load    = (opcode == OP_LW);
        dec.is_bne     = (opcode == OP_BNE);

        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin
                        dec.dispatch   = S_EXEC;
                        dec.illegal    = 1'b0;
                        dec.exec_ula   = ULA_ADD;
                        dec.exec_traps = 1'b1;
                    end
                    FN_SUB: begin
                        dec.dispatch   = S_EXEC;
                        dec.illegal    = 1'b0;
                        dec.exec_ula   = ULA_SUB;
                        dec.exec_traps = 1'b1;
                    end
                    FN_AND: begin
                        dec.dispatch   = S_EXEC;
                        dec.illegal    = 1'b0;
                        dec.exec_ula   = ULA_AND;
                    end
                    FN_SLT: begin
                        dec.dispatch = S_SLT;
                        dec.illegal  = 1'b0;
                    end
                    FN_JR: begin
                        dec.dispatch = S_JR;
                        dec.illegal  = 1'b0;
                    end
                    default: ;
                endcase
            end
            OP_ADDI: begin
                dec.dispatch   = S_EXEC;
                dec.illegal    = 1'b0;
                dec.exec_ula   = ULA_ADD;
                dec.exec_traps = 1'b1;
            end
            OP_LW, OP_SW: begin
                dec.dispatch = S_ADDR;
                dec.illegal  = 1'b0;
            end
            OP_BEQ, OP_BNE: begin
                dec.dispatch = S_BRANCH;
                dec.illegal  = 1'b0;
            end
            OP_LUI: begin
                dec.dispatch = S_LUI;
                dec.illegal  = 1'b0;
            end
            OP_J: begin
                dec.dispatch = S_JUMP;
                dec.illegal  = 1'b0;
            end
            OP_JAL: begin
                dec.dispatch = S_JAL1;
                dec.illegal  = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: multicycle main control FSM of the MIPS CPU. Sequences
// fetch, decode, execute, memory, write-back and exception entry, and drives
// every mux select and load enable of the datapath. Outputs depend on the
// state only, except PCWrite in BRANCH (uses eg).
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int RESET_SP = 227  // $29 reset value; the datapath supplies it as mux constant 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       overflow,
    input  logic       eg,
    input  logic       lt,
    output logic [1:0] IorD,
    output logic [1:0] ExcpCtrl,
    output logic [1:0] RegDist,
    output logic [2:0] MemtoReg,
    output logic [1:0] ALUSrcA,
    output logic [2:0] ALUSrcB,
    output logic [2:0] ULAcontrol,
    output logic [1:0] PCSrc,
    output logic       PCWrite,
    output logic       IRwrite,
    output logic       RegWrite,
    output logic       LoadA,
    output logic       LoadB,
    output logic       ALUOutCtrl,
    output logic       EPCControl,
    output logic       MDRWrite,
    output logic       MemWr,
    output logic       WriteData,
    output logic [4:0] state
);

    state_t state_q;
    state_t state_d;
    exc_t   exc_code_q;
    dec_t   dec;

    // lt reaches the register file through the slt mux, not through control;
    // RESET_SP is realised in the datapath. Neither drives any decision here.
    logic unused_ok;
    assign unused_ok = ^{lt, RESET_SP[0]};

    ctrl_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .dec    (dec)
    );

    assign state = state_q;

    // Next-state selection; only EXEC looks at an ALU flag.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:      state_d = S_FETCH;
            S_FETCH:      state_d = S_FETCH_WAIT;
            S_FETCH_WAIT: state_d = S_DECODE;
            S_DECODE:     state_d = dec.dispatch;
            S_EXEC:       state_d = (overflow && dec.exec_traps) ? S_EXC : S_WB;
            S_WB:         state_d = S_FETCH;
            S_SLT:        state_d = S_FETCH;
            S_ADDR:       state_d = dec.is_load ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:     state_d = S_MEM_WAIT;
            S_MEM_WAIT:   state_d = S_MEM_WB;
            S_MEM_WB:     state_d = S_FETCH;
            S_MEM_WR:     state_d = S_FETCH;
            S_BRANCH:     state_d = S_FETCH;
            S_JR:         state_d = S_FETCH;
            S_LUI:        state_d = S_FETCH;
            S_JUMP:       state_d = S_FETCH;
            S_JAL1:       state_d = S_JAL2;
            S_JAL2:       state_d = S_FETCH;
            S_EXC:        state_d = S_EXC_WAIT;
            S_EXC_WAIT:   state_d = S_EXC_JUMP;
            S_EXC_JUMP:   state_d = S_FETCH;
            // Unused encodings resume at FETCH rather than re-running the $29 init.
            default:      state_d = S_FETCH;
        endcase
    end

    // State register and exception-cause register, synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: registers are updated with non-blocking assignments so every
        // flop samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q    <= S_RESET;
            exc_code_q <= EXC_OPCODE;
        end else begin
            state_q <= state_d;
            // Cause is captured once on entry: from DECODE the instruction is
            // illegal, from EXEC it overflowed.
            if (state_d == S_EXC && state_q != S_EXC) begin
                exc_code_q <= dec.illegal ? EXC_OPCODE : EXC_OVF;
            end
        end
    end

    // Moore output decode; anything a state does not mention stays 0.
    always_comb begin
        IorD       = IORD_PC;
        ExcpCtrl   = EXC_OPCODE;
        RegDist    = RD_RT;
        MemtoReg   = MTR_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_B;
        ULAcontrol = ULA_PASS;
        PCSrc      = PC_ALURES;
        PCWrite    = 1'b0;
        IRwrite    = 1'b0;
        RegWrite   = 1'b0;
        LoadA      = 1'b0;
        LoadB      = 1'b0;
        ALUOutCtrl = 1'b0;
        EPCControl = 1'b0;
        MDRWrite   = 1'b0;
        MemWr      = 1'b0;
        WriteData  = 1'b0;

        case (state_q)
            S_RESET: begin
                // $29 <= RESET_SP via the constant input of the write-data mux.
                RegDist  = RD_SP;
                MemtoReg = MTR_SP;
                RegWrite = 1'b1;
            end
            S_FETCH: begin
                IorD       = IORD_PC;
                ALUSrcA    = SRCA_PC;
                ALUSrcB    = SRCB_FOUR;
                ULAcontrol = ULA_ADD;
            end
            S_FETCH_WAIT: begin
                IorD       = IORD_PC;
                ALUSrcA    = SRCA_PC;
                ALUSrcB    = SRCB_FOUR;
                ULAcontrol = ULA_ADD;
                IRwrite    = 1'b1;
                PCWrite    = 1'b1;
                PCSrc      = PC_ALURES;
            end
            S_DECODE: begin
                // A/B load from the register file; ALUOut takes the branch target.
                LoadA      = 1'b1;
                LoadB      = 1'b1;
                ALUSrcA    = SRCA_PC;
                ALUSrcB    = SRCB_BROFF;
                ULAcontrol = ULA_ADD;
                ALUOutCtrl = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = dec.is_rtype ? SRCB_B : SRCB_IMM;
                ULAcontrol = dec.exec_ula;
                ALUOutCtrl = 1'b1;
            end
            S_WB: begin
                MemtoReg = MTR_ALUOUT;
                RegDist  = dec.is_rtype ? RD_RD : RD_RT;
                RegWrite = 1'b1;
            end
            S_SLT: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_B;
                ULAcontrol = ULA_CMP;
                MemtoReg   = MTR_SLT;
                RegDist    = RD_RD;
                RegWrite   = 1'b1;
            end
            S_ADDR: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_IMM;
                ULAcontrol = ULA_ADD;
                ALUOutCtrl = 1'b1;
            end
            S_MEM_RD: begin
                IorD = IORD_ALUOUT;
            end
            S_MEM_WAIT: begin
                // Second cycle of the held address; read data is valid now.
                IorD     = IORD_ALUOUT;
                MDRWrite = 1'b1;
            end
            S_MEM_WB: begin
                MemtoReg = MTR_LS;
                RegDist  = RD_RT;
                RegWrite = 1'b1;
            end
            S_MEM_WR: begin
                IorD      = IORD_ALUOUT;
                WriteData = 1'b1;
                MemWr     = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_B;
                ULAcontrol = ULA_CMP;
                PCSrc      = PC_ALUOUT;
                PCWrite    = dec.is_bne ? ~eg : eg;
            end
            S_JR: begin
                ALUSrcA    = SRCA_A;
                ULAcontrol = ULA_PASS;
                PCSrc      = PC_ALURES;
                PCWrite    = 1'b1;
            end
            S_LUI: begin
                MemtoReg = MTR_LUI;
                RegDist  = RD_RT;
                RegWrite = 1'b1;
            end
            S_JUMP: begin
                PCSrc   = PC_JUMP;
                PCWrite = 1'b1;
            end
            S_JAL1: begin
                // PC (already +4) passes through the ALU into ALUOut as the link.
                ALUSrcA    = SRCA_PC;
                ULAcontrol = ULA_PASS;
                ALUOutCtrl = 1'b1;
            end
            S_JAL2: begin
                RegDist  = RD_RA;
                MemtoReg = MTR_ALUOUT;
                RegWrite = 1'b1;
                PCSrc    = PC_JUMP;
                PCWrite  = 1'b1;
            end
            S_EXC: begin
                // EPC <= PC - 4, and start reading the vector byte for this cause.
                ALUSrcA    = SRCA_PC;
                ALUSrcB    = SRCB_FOUR;
                ULAcontrol = ULA_SUB;
                EPCControl = 1'b1;
                IorD       = IORD_EXCVEC;
                ExcpCtrl   = exc_code_q;
            end
            S_EXC_WAIT: begin
                IorD     = IORD_EXCVEC;
                ExcpCtrl = exc_code_q;
                MDRWrite = 1'b1;
            end
            S_EXC_JUMP: begin
                ALUSrcA    = SRCA_MDR;
                ULAcontrol = ULA_PASS;
                PCSrc      = PC_ALURES;
                PCWrite    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
